instr_issue_unit: RTL and testbench

- Instruction source that drives the 4-stage core's 32-bit instruction input, one word per clock.
- Holds a small loadable program store and a program counter.
- Detects read-after-write hazards against recently issued instructions and inserts NOP bubbles, because the core has no forwarding.
- After HALT it drains the core with NOPs, then reports done.

---
 rtl/isa_pkg.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 60 ++++++
 rtl/instr_issue_unit.sv | 167 ++++++++++++++++
 tb/tb_instr_issue_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 4-stage core and its instruction issue unit.
// Contents: opcode values, the canonical NOP word, instruction field bit
// positions, the issue FSM state type, and opcode classification helpers.
package isa_pkg;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_LOAD = 6'b000010;
   localparam logic [5:0] OP_HALT = 6'b111110;
   localparam logic [5:0] OP_NOP  = 6'b111111;

   // Opcode 0 is a real ADD, so bubbles must use this all-ones-opcode word.
   localparam logic [31:0] NOP_WORD = 32'hFC00_0000;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int RD_MSB  = 25;
   localparam int RD_LSB  = 21;
   localparam int RS1_MSB = 20;
   localparam int RS1_LSB = 16;
   localparam int RS2_MSB = 15;
   localparam int RS2_LSB = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_STALL,
      ST_DRAIN,
      ST_DONE
   } issue_state_t;

   function automatic logic is_writer(input logic [5:0] opcode);
      return (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_LOAD);
   endfunction

   function automatic logic reads_rs1(input logic [5:0] opcode);
      return (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_LOAD);
   endfunction

   function automatic logic reads_rs2(input logic [5:0] opcode);
      return (opcode == OP_ADD) || (opcode == OP_SUB);
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Read-after-write scoreboard for the issue unit.
// Keeps the destination registers of the last HAZARD_DIST-1 issue slots and
// flags a hazard when the candidate word reads any of them.
// Ports: clk, reset (async, active high), flush (clear all entries),
//        shift (advance one issue slot), wr_valid/wr_rd (entry shifted in),
//        rs1/rs2 + rs1_used/rs2_used (candidate sources), hazard (match).
module hazard_scoreboard #(
   parameter int HAZARD_DIST = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       shift,
   input  logic       wr_valid,
   input  logic [4:0] wr_rd,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       rs1_used,
   input  logic       rs2_used,
   output logic       hazard
);

   localparam int ENTRIES = HAZARD_DIST - 1;

   generate
      if (ENTRIES > 0) begin : g_sb
         logic [ENTRIES-1:0] vld;
         logic [4:0]         rd_q [ENTRIES];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               vld <= '0;
               for (int i = 0; i < ENTRIES; i++) rd_q[i] <= '0;
            end else if (flush) begin
               vld <= '0;
            end else if (shift) begin
               vld[0]  <= wr_valid;
               rd_q[0] <= wr_rd;
               for (int i = 1; i < ENTRIES; i++) begin
                  vld[i]  <= vld[i-1];
                  rd_q[i] <= rd_q[i-1];
               end
            end
         end

         // r0 is compared like any other register; the core does not hardwire it.
         always_comb begin
            hazard = 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
               if (vld[i] && ((rs1_used && (rd_q[i] == rs1)) ||
                              (rs2_used && (rd_q[i] == rs2))))
                  hazard = 1'b1;
            end
         end
      end else begin : g_none
         assign hazard = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction issue unit: loadable program store + PC feeding the 4-stage
// core one 32-bit word per clock, inserting NOP bubbles on RAW hazards (the
// core has no forwarding) and draining the pipeline with NOPs after HALT.
// Ports: clk, reset (async, active high); prog_we/prog_addr/prog_wdata
//        (store write, honoured in IDLE/DONE only); start; instruction_out,
//        issue_valid, pc_out, busy, done.
// Optional: define ISSUE_STATS_EN to add bubble_count / issued_count outputs
//        (saturating 16-bit, cleared on reset and on an accepted start).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start after reset; store writable
// ST_RUN   | issuing one program word per cycle
// ST_STALL | holding PC, issuing bubbles until the hazard clears
// ST_DRAIN | HALT seen, issuing NOPs so the last word reaches writeback
// ST_DONE  | run complete; store writable, start re-runs from PC 0
module instr_issue_unit
   import isa_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int HAZARD_DIST  = 2,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [31:0]              prog_wdata,
   input  logic                     start,
   output logic [31:0]              instruction_out,
   output logic                     issue_valid,
   output logic [$clog2(DEPTH)-1:0] pc_out,
   output logic                     busy,
   output logic                     done
`ifdef ISSUE_STATS_EN
  ,output logic [15:0]              bubble_count,
   output logic [15:0]              issued_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   issue_state_t   state, state_d;
   logic [AW-1:0]  pc, pc_d;
   logic           end_flag, end_d;
   logic [CW-1:0]  cnt, cnt_d;
   logic [31:0]    instr_d;
   logic           valid_d;
   logic           sb_shift, sb_wr, sb_flush, hazard;
   logic           bubble, run_start;

   logic [31:0]    prog_mem [DEPTH];
   logic [31:0]    cur_word;
   logic [5:0]     cur_op;
   logic           cur_halt;

   assign cur_word = prog_mem[pc];
   assign cur_op   = cur_word[OPC_MSB:OPC_LSB];
   // Past the last store word the run ends as if HALT were there.
   assign cur_halt = end_flag || (cur_op == OP_HALT);

   always_ff @(posedge clk) begin
      if (prog_we && ((state == ST_IDLE) || (state == ST_DONE)))
         prog_mem[prog_addr] <= prog_wdata;
   end

   hazard_scoreboard #(.HAZARD_DIST(HAZARD_DIST)) u_sb (
      .clk      (clk),
      .reset    (reset),
      .flush    (sb_flush),
      .shift    (sb_shift),
      .wr_valid (sb_wr),
      .wr_rd    (cur_word[RD_MSB:RD_LSB]),
      .rs1      (cur_word[RS1_MSB:RS1_LSB]),
      .rs2      (cur_word[RS2_MSB:RS2_LSB]),
      .rs1_used (reads_rs1(cur_op)),
      .rs2_used (reads_rs2(cur_op)),
      .hazard   (hazard)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         pc              <= '0;
         end_flag        <= 1'b0;
         cnt             <= '0;
         instruction_out <= NOP_WORD;
         issue_valid     <= 1'b0;
      end else begin
         state           <= state_d;
         pc              <= pc_d;
         end_flag        <= end_d;
         cnt             <= cnt_d;
         instruction_out <= instr_d;
         issue_valid     <= valid_d;
      end
   end

   always_comb begin
      state_d   = state;
      pc_d      = pc;
      end_d     = end_flag;
      cnt_d     = cnt;
      instr_d   = NOP_WORD;
      valid_d   = 1'b0;
      sb_shift  = 1'b0;
      sb_wr     = 1'b0;
      sb_flush  = 1'b0;
      bubble    = 1'b0;
      run_start = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               run_start = 1'b1;
               sb_flush  = 1'b1;
               state_d   = ST_RUN;
               pc_d      = '0;
               end_d     = 1'b0;
            end
         end
         ST_RUN, ST_STALL: begin
            sb_shift = 1'b1;
            if (cur_halt) begin
               state_d = ST_DRAIN;
               cnt_d   = CW'(DRAIN_CYCLES - 1);
            end else if (hazard) begin
               state_d = ST_STALL;
               bubble  = 1'b1;
            end else begin
               state_d = ST_RUN;
               instr_d = cur_word;
               valid_d = 1'b1;
               sb_wr   = is_writer(cur_op);
               if (pc == AW'(DEPTH - 1)) end_d = 1'b1;
               else                      pc_d  = pc + AW'(1);
            end
         end
         ST_DRAIN: begin
            sb_shift = 1'b1;
            if (cnt == '0) state_d = ST_DONE;
            else           cnt_d   = cnt - CW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign pc_out = pc;
   assign busy   = (state == ST_RUN) || (state == ST_STALL) || (state == ST_DRAIN);
   assign done   = (state == ST_DONE);

`ifdef ISSUE_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_count <= '0;
         issued_count <= '0;
      end else if (run_start) begin
         bubble_count <= '0;
         issued_count <= '0;
      end else begin
         if (bubble && (bubble_count != 16'hFFFF)) bubble_count <= bubble_count + 16'd1;
         if (valid_d && (issued_count != 16'hFFFF)) issued_count <= issued_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
module tb_instr_issue_unit;
   localparam int DEPTH = 64;
   localparam int HD    = 2;
   localparam int DRAIN = 3;
   localparam logic [31:0] NOPW  = 32'hFC000000;
   localparam logic [31:0] HALTW = 32'hF8000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        prog_we;
   logic [5:0]  prog_addr;
   logic [31:0] prog_wdata;
   logic        start;
   logic [31:0] instruction_out;
   logic        issue_valid;
   logic [5:0]  pc_out;
   logic        busy;
   logic        done;
`ifdef ISSUE_STATS_EN
   logic [15:0] bubble_count;
   logic [15:0] issued_count;
`endif

   instr_issue_unit #(.DEPTH(DEPTH), .HAZARD_DIST(HD), .DRAIN_CYCLES(DRAIN)) dut (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_wdata(prog_wdata), .start(start), .instruction_out(instruction_out),
      .issue_valid(issue_valid), .pc_out(pc_out), .busy(busy), .done(done)
`ifdef ISSUE_STATS_EN
     ,.bubble_count(bubble_count), .issued_count(issued_count)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        we;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic        st;
      logic [31:0] e_instr;
      logic        e_valid, e_busy, e_done;
      logic [5:0]  e_pc;
   } vec_t;
   vec_t tbl[$];

   typedef struct {
      logic [31:0] w;
      logic        v, b, d;
      logic [5:0]  pc;
   } exp_t;
   exp_t exp_q[$];

   logic [31:0] prog [DEPTH];
   int m_bubbles, m_issued;

   task automatic chk(input string name, input logic [31:0] ei, input logic ev,
                      input logic eb, input logic ed, input logic [5:0] ep);
      n_vec++;
      if (instruction_out !== ei || issue_valid !== ev || busy !== eb ||
          done !== ed || pc_out !== ep) begin
         n_err++;
         $display("FAIL %s: got instr=%h v=%b busy=%b done=%b pc=%0d, want instr=%h v=%b busy=%b done=%b pc=%0d",
                  name, instruction_out, issue_valid, busy, done, pc_out, ei, ev, eb, ed, ep);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic add_v(input logic we, input logic [5:0] a, input logic [31:0] wd, input logic st,
                        input logic [31:0] ei, input logic ev, input logic eb, input logic ed,
                        input logic [5:0] ep);
      vec_t r;
      r.we = we; r.addr = a; r.wdata = wd; r.st = st;
      r.e_instr = ei; r.e_valid = ev; r.e_busy = eb; r.e_done = ed; r.e_pc = ep;
      tbl.push_back(r);
   endtask

   // Reference: each register remembers the issue slot of its last writer;
   // a reader must sit at least HD slots later, otherwise the slot is a bubble.
   task automatic build_model();
      int last_wr [32];
      int pc, slot;
      bit ended;
      logic [31:0] w;
      logic [5:0] op;
      int rd, r1, r2;
      bit u1, u2, haz;
      exp_t e;
      exp_q.delete();
      m_bubbles = 0; m_issued = 0;
      for (int r = 0; r < 32; r++) last_wr[r] = -1000;
      pc = 0; slot = 0; ended = 0;
      for (int guard = 0; guard < 500; guard++) begin
         w  = prog[pc];
         op = w[31:26]; rd = int'(w[25:21]); r1 = int'(w[20:16]); r2 = int'(w[15:11]);
         if (ended || op == 6'b111110) begin
            for (int d = 0; d < DRAIN; d++) begin
               e.w = NOPW; e.v = 0; e.b = 1; e.d = 0; e.pc = 6'(pc); exp_q.push_back(e);
            end
            e.w = NOPW; e.v = 0; e.b = 0; e.d = 1; e.pc = 6'(pc); exp_q.push_back(e);
            break;
         end
         u1  = (op == 6'd0 || op == 6'd1 || op == 6'd2);
         u2  = (op == 6'd0 || op == 6'd1);
         haz = (u1 && (slot - last_wr[r1] < HD)) || (u2 && (slot - last_wr[r2] < HD));
         if (haz) begin
            m_bubbles++;
            e.w = NOPW; e.v = 0; e.b = 1; e.d = 0; e.pc = 6'(pc);
         end else begin
            m_issued++;
            if (u1) last_wr[rd] = slot;
            if (pc == DEPTH - 1) ended = 1; else pc++;
            e.w = w; e.v = 1; e.b = 1; e.d = 0; e.pc = 6'(pc);
         end
         exp_q.push_back(e);
         slot++;
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < DEPTH; i++) begin
         prog_we = 1; prog_addr = 6'(i); prog_wdata = prog[i];
         @(posedge clk); #1;
      end
      prog_we = 0;
   endtask

   task automatic run_and_check(input string name, input bit do_load, input bit scribble);
      if (do_load) load_prog();
      build_model();
      start = 1;
      @(posedge clk); #1;
      start = 0;
      chk({name, "_start"}, NOPW, 0, 1, 0, 6'd0);
      for (int k = 0; k < exp_q.size(); k++) begin
         if (scribble && k == 1) begin
            prog_we = 1; prog_addr = 6'd0; prog_wdata = ~prog[0];
         end else begin
            prog_we = 0;
         end
         @(posedge clk); #1;
         chk($sformatf("%s_slot%0d", name, k), exp_q[k].w, exp_q[k].v, exp_q[k].b,
             exp_q[k].d, exp_q[k].pc);
      end
      prog_we = 0;
`ifdef ISSUE_STATS_EN
      chk16({name, "_bubbles"}, bubble_count, 16'(m_bubbles));
      chk16({name, "_issued"}, issued_count, 16'(m_issued));
`endif
   endtask

   initial begin
      int nv;
      logic [5:0] op;
      int hpos, sel;
      bit seen;

      reset = 1; prog_we = 0; prog_addr = '0; prog_wdata = '0; start = 0;
      #1;
      chk("reset", NOPW, 0, 0, 0, 6'd0);
      @(posedge clk); #1;
      reset = 0;

      // Independent stream, then RAW hazard, then LOAD with rs2 bits = 3
      // written in the same cycle as start.
      add_v(1, 6'd0, 32'h00611000, 0, NOPW, 0, 0, 0, 6'd0);
      add_v(1, 6'd1, 32'h08A00008, 0, NOPW, 0, 0, 0, 6'd0);
      add_v(1, 6'd2, HALTW,        0, NOPW, 0, 0, 0, 6'd0);
      add_v(0, 6'd0, 0, 1, NOPW,         0, 1, 0, 6'd0);
      add_v(0, 6'd0, 0, 0, 32'h00611000, 1, 1, 0, 6'd1);
      add_v(0, 6'd0, 0, 0, 32'h08A00008, 1, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 0, 1, 6'd2);
      add_v(1, 6'd1, 32'h04830800, 0, NOPW, 0, 0, 1, 6'd2);
      add_v(0, 6'd0, 0, 1, NOPW,         0, 1, 0, 6'd0);
      add_v(0, 6'd0, 0, 0, 32'h00611000, 1, 1, 0, 6'd1);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 1, 0, 6'd1);
      add_v(0, 6'd0, 0, 0, 32'h04830800, 1, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 0, 1, 6'd2);
      add_v(1, 6'd1, 32'h08A01800, 1, NOPW, 0, 1, 0, 6'd0);
      add_v(0, 6'd0, 0, 0, 32'h00611000, 1, 1, 0, 6'd1);
      add_v(0, 6'd0, 0, 0, 32'h08A01800, 1, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 1, 0, 6'd2);
      add_v(0, 6'd0, 0, 0, NOPW,         0, 0, 1, 6'd2);
      for (int i = 0; i < tbl.size(); i++) begin
         prog_we = tbl[i].we; prog_addr = tbl[i].addr; prog_wdata = tbl[i].wdata; start = tbl[i].st;
         @(posedge clk); #1;
         chk($sformatf("table%0d", i), tbl[i].e_instr, tbl[i].e_valid, tbl[i].e_busy,
             tbl[i].e_done, tbl[i].e_pc);
      end
      prog_we = 0; start = 0;
`ifdef ISSUE_STATS_EN
      chk16("table_bubbles", bubble_count, 16'd0);
      chk16("table_issued", issued_count, 16'd2);
`endif

      // RAW hazard through the full model, including bubble statistics.
      for (int i = 0; i < DEPTH; i++) prog[i] = HALTW;
      prog[0] = 32'h00611000; prog[1] = 32'h04830800;
      run_and_check("raw", 1, 0);

      // Implicit end: every word is ADD r1,r0,r0.
      for (int i = 0; i < DEPTH; i++) prog[i] = 32'h00200000;
      run_and_check("implicit_end", 1, 0);

      // Reset at the third issue, then replay from the retained store.
      for (int i = 0; i < DEPTH; i++) prog[i] = HALTW;
      for (int i = 0; i < 6; i++) prog[i] = 32'h00000000 | (32'(i + 1) << 21);
      load_prog();
      start = 1; @(posedge clk); #1; start = 0;
      nv = 0; seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk); #1;
         if (issue_valid === 1'b1) nv++;
         if (nv == 3) seen = 1;
      end
      if (!seen) begin
         n_vec++; n_err++;
         $display("FAIL reset_mid_run_wait: got %0d issues, want 3 within 20 cycles", nv);
      end
      reset = 1; #1;
      chk("reset_mid_run", NOPW, 0, 0, 0, 6'd0);
      @(posedge clk); #1;
      reset = 0;
      run_and_check("replay", 0, 0);

      // A store write while busy must be ignored.
      run_and_check("scribble", 0, 1);
      run_and_check("after_scribble", 0, 0);

      // Random programs over r0..r3 so hazards are frequent.
      for (int t = 0; t < 30; t++) begin
         hpos = $urandom_range(2, 72);
         for (int i = 0; i < DEPTH; i++) begin
            sel = $urandom_range(0, 9);
            op = (sel < 4) ? 6'b000000 : (sel < 6) ? 6'b000001 : (sel < 9) ? 6'b000010 : 6'b111111;
            prog[i] = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 11'($urandom)};
            if (i == hpos) prog[i] = HALTW;
         end
         run_and_check($sformatf("rand%0d", t), 1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
